// File: rtl/router_pkg.sv
// Shared defaults, FSM state type and pointer helper for the round-robin router arbiter.
package router_pkg;

  localparam int ROUTER_ADDR_WIDTH = 32;
  localparam int ROUTER_DATA_WIDTH = 32;
  localparam int ROUTER_NUM_PORTS  = 4;
  localparam int ROUTER_CNT_WIDTH  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Modulo increment used to advance the round-robin pointer past the last winner.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/router_rr_arbiter_if.sv
// Input-port bundle and output channel of the router arbiter.
// ROUTER_ARB_STATS_EN adds the packed per-port packet counters.
interface router_rr_arbiter_if #(
  parameter int NUM_PORTS  = router_pkg::ROUTER_NUM_PORTS,
  parameter int ADDR_WIDTH = router_pkg::ROUTER_ADDR_WIDTH,
  parameter int DATA_WIDTH = router_pkg::ROUTER_DATA_WIDTH
`ifdef ROUTER_ARB_STATS_EN
  , parameter int CNT_WIDTH = router_pkg::ROUTER_CNT_WIDTH
`endif
);
  localparam int SRC_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_last;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [ADDR_WIDTH-1:0]           out_addr;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [SRC_W-1:0]                out_src;
  logic                            out_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_PORTS-1:0]            grant;
  logic                            busy;
`ifdef ROUTER_ARB_STATS_EN
  logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count;

  modport master (
    output in_addr, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_addr, out_data, out_src, out_last, out_valid, grant, busy, pkt_count
  );
  modport slave (
    input  in_addr, in_data, in_valid, in_last, out_ready,
    output in_ready, out_addr, out_data, out_src, out_last, out_valid, grant, busy, pkt_count
  );
`else
  modport master (
    output in_addr, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_addr, out_data, out_src, out_last, out_valid, grant, busy
  );
  modport slave (
    input  in_addr, in_data, in_valid, in_last, out_ready,
    output in_ready, out_addr, out_data, out_src, out_last, out_valid, grant, busy
  );
`endif

endinterface

// File: rtl/router_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo NUM_PORTS.
module rr_pick #(
  parameter  int NUM_PORTS = 4,
  localparam int SRC_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SRC_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_onehot,
  output logic [SRC_W-1:0]     o_idx,
  output logic                 o_any
);

  always_comb begin
    int j;
    j        = 0;
    o_idx    = '0;
    o_any    = |i_req;
    // Walk from farthest to nearest so the closest requester to the pointer wins last.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_PORTS) begin
        j = j - NUM_PORTS;
      end
      if (i_req[j]) begin
        o_idx = SRC_W'(j);
      end
    end
    o_onehot = o_any ? (NUM_PORTS'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/router_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered router output channel.
// Optional feature macro: ROUTER_ARB_STATS_EN (per-port saturating packet counters).
module router_rr_arbiter
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH = ROUTER_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int NUM_PORTS  = ROUTER_NUM_PORTS
`ifdef ROUTER_ARB_STATS_EN
  , parameter int CNT_WIDTH = ROUTER_CNT_WIDTH
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  router_rr_arbiter_if.slave   bus
);

  localparam int SRC_W = $clog2(NUM_PORTS);

  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign w_addr_arr[gi] = bus.in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_data_arr[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  arb_state_t            r_state;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic [SRC_W-1:0]      r_owner;
  logic [NUM_PORTS-1:0]  r_grant;
  logic                  r_busy;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0]      r_out_src;

  logic [NUM_PORTS-1:0]  w_pick_onehot;
  logic [SRC_W-1:0]      w_pick_idx;
  logic                  w_pick_any;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .i_req    (bus.in_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  logic                 w_locked;
  logic                 w_can_load;
  logic [SRC_W-1:0]     w_sel_idx;
  logic [NUM_PORTS-1:0] w_sel_onehot;
  logic                 w_sel_req;
  logic                 w_offer;
  logic                 w_xfer;
  logic                 w_sel_last;

  assign w_locked     = (r_state == LOCKED);
  assign w_can_load   = !r_out_valid || bus.out_ready;
  assign w_sel_idx    = w_locked ? r_owner : w_pick_idx;
  assign w_sel_onehot = w_locked ? (NUM_PORTS'(1) << r_owner) : w_pick_onehot;
  assign w_sel_req    = w_locked ? bus.in_valid[r_owner] : w_pick_any;
  // The owner is offered ready even while it idles mid-packet; reset forces every ready low.
  assign w_offer      = reset && w_can_load && (w_locked || w_pick_any);
  assign w_xfer       = w_offer && w_sel_req;
  assign w_sel_last   = bus.in_last[w_sel_idx];

  assign bus.in_ready  = w_offer ? w_sel_onehot : '0;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_sel_last;
        r_out_addr  <= w_addr_arr[w_sel_idx];
        r_out_data  <= w_data_arr[w_sel_idx];
        r_out_src   <= w_sel_idx;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_sel_last) begin
              r_rr_ptr <= SRC_W'(rr_next(32'(w_pick_idx), unsigned'(NUM_PORTS)));
            end else begin
              r_state <= LOCKED;
              r_owner <= w_pick_idx;
              r_grant <= w_pick_onehot;
              r_busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_xfer && w_sel_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= SRC_W'(rr_next(32'(r_owner), unsigned'(NUM_PORTS)));
            r_grant  <= '0;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_pkt_count [NUM_PORTS];

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pkt_count[gi] <= '0;
        end else if (w_xfer && w_sel_last && (w_sel_idx == SRC_W'(gi)) && (r_pkt_count[gi] != '1)) begin
          r_pkt_count[gi] <= r_pkt_count[gi] + CNT_WIDTH'(1);
        end
      end
      assign bus.pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_pkt_count[gi];
    end
  endgenerate
`endif

endmodule

// File: doc/router_rr_arbiter.md
Name: router_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit router output channel among NUM_PORTS input ports.
- Inputs use per-port valid/ready handshake with multi-beat packets (in_last marks the final beat); the grant is locked to one port for a whole packet.
- A single registered output stage with valid/ready backpressure feeds the downstream router port or link.
- Sits in front of each Router32 output lane and resolves contention when several inputs target the same destination.

Parameters:
- ADDR_WIDTH, 32, address width per port
- DATA_WIDTH, 32, data width per port
- NUM_PORTS, 4, number of requesting input ports (>=2)
- SRC_W, $clog2(NUM_PORTS), source-index width (localparam)
- CNT_WIDTH, 16, statistics counter width (used only with ROUTER_ARB_STATS_EN)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- in_data  in  NUM_PORTS*DATA_WIDTH  packed per-port data, same packing
- in_valid  in  NUM_PORTS  per-port beat valid
- in_last  in  NUM_PORTS  per-port final-beat flag, qualified by in_valid
- in_ready  out  NUM_PORTS  per-port beat accept, at most one bit set
- out_addr  out  ADDR_WIDTH  registered address of the granted beat
- out_data  out  DATA_WIDTH  registered data of the granted beat
- out_src  out  SRC_W  index of the port that produced the beat
- out_last  out  1  registered final-beat flag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- grant  out  NUM_PORTS  one-hot current packet owner; 0 when IDLE
- busy  out  1  1 while state is LOCKED

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, owner=0, out_valid=0, out_last=0, out_addr=0, out_data=0, out_src=0, in_ready=0, grant=0, busy=0.
- Beat transfer rule: a beat transfers on port i when in_valid[i] & in_ready[i] at a clk edge.
- Output-stage readiness: can_load = !out_valid | out_ready.
- FSM states: IDLE, LOCKED.
- IDLE arbitration:
  - The winner is the first port with in_valid set, searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - in_ready[winner] = can_load; all other in_ready bits are 0.
  - On transfer with in_last=1: stay IDLE, rr_ptr <= winner+1 (mod NUM_PORTS).
  - On transfer with in_last=0: go to LOCKED, owner <= winner.
- LOCKED:
  - in_ready[owner] = can_load; all other in_ready bits are 0; requests from other ports are ignored.
  - grant = onehot(owner).
  - On transfer with in_last=1: go to IDLE, rr_ptr <= owner+1 (mod NUM_PORTS).
- Output register:
  - On transfer, load addr/data/last/src into the output register and set out_valid=1.
  - If out_valid & out_ready and no new transfer: out_valid <= 0.
  - Payload is held stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of 1 beat/cycle while out_ready=1.
- Simultaneous events: output drain and new load in the same cycle load the new beat, and out_valid stays 1.
- Pointer wrap: rr_ptr at NUM_PORTS-1 +1 wraps to 0.
- Boundary cases:
  - in_valid dropped by the owner mid-packet: remain LOCKED, no transfer, no timeout.
  - All in_valid=0: no transfer, rr_ptr unchanged.
- Reset mid-packet: returns to IDLE immediately; the partial packet and any pending output beat are discarded.
- Single-beat packets never enter LOCKED.

Optional Feature:
- Macro: ROUTER_ARB_STATS_EN.
- Defined:
  - Adds output port pkt_count (NUM_PORTS*CNT_WIDTH), one saturating counter per port.
  - Counter i increments on each accepted last beat from port i and holds at all-ones.
  - Counters clear to 0 on reset.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package router_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - NUM_PORTS default
  - FSM state enum {IDLE, LOCKED}
  - rr_next helper function (modulo increment).
- Sub-module rr_pick (combinational, NUM_PORTS-generic):
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_req.
- The FSM, output register and stats logic live in router_rr_arbiter.

Test Plan:
- Reset mid-traffic: drive reset=0 while out_valid=1 and LOCKED → out_valid=0, grant=0, busy=0, in_ready=0 asynchronously; after release, the first winner is port 0.
- Round-robin fairness: in_valid=4'b1111 with single-beat packets, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles; out_data matches the per-port values (e.g. 32'h000000A0+i).
- Packet lock: port 1 sends a 3-beat packet (last on beat 3) while port 2 is valid → out_src=1 for 3 consecutive beats, then port 2 is served; grant=4'b0010 and busy=1 during the packet.
- Backpressure: out_ready=0 for 4 cycles after the first beat → out_data is held at its first value, in_ready=0 for all ports, no beat is lost; after out_ready=1 the beats resume in order.
- Pointer wrap and idle gap: port 3 wins, then only port 0 is valid → port 0 is granted; with in_valid=0 for 5 cycles, rr_ptr is unchanged and out_valid deasserts after drain.
- With ROUTER_ARB_STATS_EN: 3 packets from port 2 and 1 from port 0 → pkt_count[2]=3, pkt_count[0]=1, others 0; forcing near-saturation (CNT_WIDTH=2) shows a hold at 3.
